// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipelined MIPS core.
// Holds the machine word type and icache FSM/config constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

  localparam int ICACHE_SETS_MAX = 256;
  localparam int ICACHE_WAYS_MAX = 4;

endpackage

// File: rtl/icache_lru.sv
// Per-set LRU ages for icache_assoc.
// Tracks ages per set, applies updates and picks the victim way.
module icache_lru #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [$clog2(SETS)-1:0]                sidx,
  input  logic [WAYS-1:0]                        svalid,
  output logic [((WAYS>1)?$clog2(WAYS):1)-1:0]   victim,
  input  logic                                   upd,
  input  logic [$clog2(SETS)-1:0]                uidx,
  input  logic [((WAYS>1)?$clog2(WAYS):1)-1:0]   uway
);

  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WW-1:0] age [SETS][WAYS];
  logic [WW-1:0] old;
  logic [WW-1:0] mx;
  logic          found;

  assign old = age[uidx][uway];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WW'(w);
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == uway)
          age[uidx][w] <= '0;
        else if (age[uidx][w] < old)
          age[uidx][w] <= age[uidx][w] + 1'b1;
      end
    end
  end

  // lowest invalid way first, otherwise the oldest way
  always_comb begin
    victim = '0;
    found  = 1'b0;
    mx     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !svalid[w]) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[sidx][w] >= mx) begin
          mx     = age[sidx][w];
          victim = WW'(w);
        end
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU and multi-word fill.
// Sits between the datapath fetch port and the memory i-side.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  inv,
  output logic  iREN,
  output word_t iaddr,
  input  word_t iload,
  input  logic  iwait
);

  localparam int IW = $clog2(SETS);
  localparam int BW = $clog2(WORDS);
  localparam int OW = (BW > 0) ? BW : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW = 30 - BW - IW;

  icache_state_t state;

  logic [29:0]   wa;
  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [OW-1:0] off;

  assign wa  = imemaddr[31:2];
  assign idx = IW'(wa >> BW);
  assign tag = TW'(wa >> (BW + IW));
  assign off = (BW == 0) ? '0 : OW'(wa);

  logic [SETS-1:0]      valid [WAYS];
  logic [TW-1:0]        tags  [WAYS][SETS];
  logic [WORDS*32-1:0]  data  [WAYS][SETS];

  logic [TW-1:0] ltag;
  logic [IW-1:0] lidx;
  logic [WW-1:0] vway;
  logic [WW-1:0] victim;
  logic [OW-1:0] cnt;

  logic [WAYS-1:0] hv;
  logic [WAYS-1:0] svalid;
  logic [WW-1:0]   hway;
  logic            lookup;
  logic            hit;
  logic            miss;
  logic            cap;
  logic            last;
  logic            done;
  logic [29:0]     fa;

  always_comb begin
    hv     = '0;
    svalid = '0;
    hway   = '0;
    for (int w = 0; w < WAYS; w++) begin
      svalid[w] = valid[w][idx];
      hv[w]     = svalid[w] && (tags[w][idx] == tag);
      if (hv[w])
        hway = WW'(w);
    end
  end

  assign lookup   = (state == IDLE) && imemREN && !inv;
  assign hit      = lookup && |hv;
  assign miss     = lookup && !(|hv);
  assign ihit     = hit;
  assign imemload = hit ? data[hway][idx][32*int'(off) +: 32] : '0;

  assign cap  = (state == FETCH) && !iwait;
  assign last = (cnt == OW'(WORDS - 1));
  assign done = cap && last && !inv;

  assign fa = (30'(ltag) << (IW + BW))
            | (30'(lidx) << BW)
            | ((BW == 0) ? 30'd0 : 30'(cnt));

  assign iREN  = (state == FETCH);
  assign iaddr = (state == FETCH) ? {fa, 2'b00} : '0;

  generate
    if (WAYS > 1) begin : g_lru
      icache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
      ) u_lru (
        .clk    (CLK),
        .rst_n  (nRST),
        .sidx   (idx),
        .svalid (svalid),
        .victim (victim),
        .upd    (hit || done),
        .uidx   (hit ? idx : lidx),
        .uway   (hit ? hway : vway)
      );
    end else begin : g_dm
      assign victim = '0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      ltag  <= '0;
      lidx  <= '0;
      vway  <= '0;
      for (int w = 0; w < WAYS; w++)
        valid[w] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inv) begin
            for (int w = 0; w < WAYS; w++)
              valid[w] <= '0;
          end else if (miss) begin
            ltag               <= tag;
            lidx               <= idx;
            vway               <= victim;
            cnt                <= '0;
            valid[victim][idx] <= 1'b0;
            state              <= FETCH;
          end
        end
        FETCH: begin
          if (inv) begin
            for (int w = 0; w < WAYS; w++)
              valid[w] <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (!iwait) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              valid[vway][lidx] <= 1'b1;
              state             <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // data/tag arrays need no reset; valid bits gate every use
  always_ff @(posedge CLK) begin
    if (cap)
      data[vway][lidx][32*int'(cnt) +: 32] <= iload;
    if (done)
      tags[vway][lidx] <= ltag;
  end

endmodule
